// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift_arb shifter arbiter.
// Feature macro: SHIFT_ARB_FIXED_PRIO_EN (see shift_arb.sv).
package shift_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Op is {a_or_h, l_or_r}; any op with bit 0 clear is a left shift.
  localparam logic [OP_W-1:0] OP_SHL = 2'b00;
  localparam logic [OP_W-1:0] OP_SAR = 2'b01;
  localparam logic [OP_W-1:0] OP_SHR = 2'b11;

  function automatic logic op_is_left(input logic [OP_W-1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/shift_arb_pick.sv
// Rotating-priority picker: first valid requester at or after ptr, wrapping.
module shift_arb_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned s = 0; s < NREQ; s++) begin
      cand = {1'b0, ptr} + (IW+1)'(s);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!any && req_valid[cand[IW-1:0]]) begin
        any                  = 1'b1;
        grant[cand[IW-1:0]]  = 1'b1;
        idx                  = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/shift_arb_shifter.sv
// 32-bit combinational shifter: left, arithmetic right, logical right.
module shift_arb_shifter
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [AMT_W-1:0]  amt_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    if (op_is_left(op_i)) begin
      data_o = data_i << amt_i;
    end else if (op_i == OP_SHR) begin
      data_o = data_i >> amt_i;
    end else begin
      data_o = $signed(data_i) >>> amt_i;
    end
  end

endmodule

// File: rtl/shift_arb.sv
// Shares one 32-bit shifter among NREQ requesters (IDLE -> SHIFT -> RESP).
// Define SHIFT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module shift_arb
  import shift_arb_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned RR_INIT = 0,
  localparam int unsigned IW      = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ*AMT_W-1:0]  req_amt,
  input  logic [NREQ*OP_W-1:0]   req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [IW-1:0]          rsp_id,
  output logic                   busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic [AMT_W-1:0]  cap_amt_q, cap_amt_d;
  logic [OP_W-1:0]   cap_op_q, cap_op_d;
  logic [IW-1:0]     cap_id_q, cap_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [IW-1:0]     rsp_id_q, rsp_id_d;

  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     win_idx;
  logic              win_any;
  logic [IW-1:0]     pick_ptr;
  logic [DATA_W-1:0] shift_res;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  localparam logic [IW-1:0] PTR_RST = IW'(RR_INIT);
  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && win_any) begin
      ptr_d = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PTR_RST;
    else        ptr_q <= ptr_d;
  end

  assign pick_ptr = ptr_q;
`endif

  shift_arb_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (pick_ptr),
    .grant     (grant),
    .idx       (win_idx),
    .any       (win_any)
  );

  shift_arb_shifter u_shifter (
    .data_i (cap_data_q),
    .amt_i  (cap_amt_q),
    .op_i   (cap_op_q),
    .data_o (shift_res)
  );

  always_comb begin
    state_d    = state_q;
    cap_data_d = cap_data_q;
    cap_amt_d  = cap_amt_q;
    cap_op_d   = cap_op_q;
    cap_id_d   = cap_id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          // grant is one-hot, so OR-ing the masked lanes selects the winner
          cap_data_d = '0;
          cap_amt_d  = '0;
          cap_op_d   = '0;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
              cap_data_d = cap_data_d | req_data[i*DATA_W +: DATA_W];
              cap_amt_d  = cap_amt_d  | req_amt[i*AMT_W +: AMT_W];
              cap_op_d   = cap_op_d   | req_op[i*OP_W +: OP_W];
            end
          end
          cap_id_d = win_idx;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        rsp_data_d = shift_res;
        rsp_id_d   = cap_id_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cap_data_q <= '0;
      cap_amt_q  <= '0;
      cap_op_q   <= '0;
      cap_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      cap_data_q <= cap_data_d;
      cap_amt_q  <= cap_amt_d;
      cap_op_q   <= cap_op_d;
      cap_id_q   <= cap_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  // Gated by rst_n so no accept strobe is visible while reset is held.
  assign req_ready = (state_q == ST_IDLE && rst_n) ? grant : '0;
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arb.sv
// Self-checking bench for shift_arb: vector table, directed sequences, randomized scoreboard.
module tb_shift_arb;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ*5-1:0] req_amt;
  logic [NREQ*2-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_id;
  logic              busy;

  int errors = 0;
  int checks = 0;

  shift_arb #(
    .NREQ    (NREQ),
    .RR_INIT (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [31:0] d;
    logic [4:0]  a;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  // Reference shift built from arithmetic (multiply/divide by powers of two).
  function automatic logic [31:0] model_shift(input logic [31:0] d, input logic [4:0] a,
                                              input logic [1:0] op);
    longint unsigned x, nx, pw;
    x  = {32'd0, d};
    nx = {32'd0, ~d};
    pw = 64'd1 << a;
    if (op[0] == 1'b0) return 32'(x * pw);
    if (op[1] == 1'b1) return 32'(x / pw);
    if (d[31])         return ~32'(nx / pw);
    return 32'(x / pw);
  endfunction

  function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
    for (int s = 0; s < NREQ; s++) begin
      if (v[(p + s) % NREQ]) return (p + s) % NREQ;
    end
    return -1;
  endfunction

  function automatic int model_next_ptr(input int w);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    return 0 * w;
`else
    return (w + 1) % NREQ;
`endif
  endfunction

  task automatic set_req(input int k, input logic [31:0] d, input logic [4:0] a,
                         input logic [1:0] op);
    req_data[32*k +: 32] = d;
    req_amt[5*k +: 5]    = a;
    req_op[2*k +: 2]     = op;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},  rsp_data,       32'd0);
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    next();
    next();
    rst_n = 1'b1;
  endtask

  task automatic quiesce();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) next();
  endtask

  task automatic single(input int k, input logic [31:0] d, input logic [4:0] a,
                        input logic [1:0] op, output logic [31:0] rd, output int rid,
                        output int lat, output bit ok);
    int n;
    ok = 1'b0; rd = '0; rid = -1; lat = -1;
    set_req(k, d, a, op);
    req_valid    = '0;
    req_valid[k] = 1'b1;
    rsp_ready    = 1'b1;
    #1;
    n = 0;
    while (!req_ready[k] && n < 20) begin next(); #1; n++; end
    if (!req_ready[k]) return;
    next();
    req_valid = '0;
    #1;
    lat = 1;
    while (!rsp_valid && lat < 12) begin next(); #1; lat++; end
    if (!rsp_valid) return;
    rd  = rsp_data;
    rid = int'(rsp_id);
    ok  = 1'b1;
    next();
  endtask

  vec_t        vecs[12];
  logic [31:0] rd;
  int          rid, lat, nacc, cyc, w, mptr, n;
  bit          ok, flag;
  int          order[5];
  int          when[5];
  logic [NREQ-1:0] v;
  logic [31:0] rdat[NREQ];
  logic [4:0]  ramt[NREQ];
  logic [1:0]  rop[NREQ];
  logic [33:0] q[$];
  logic [33:0] e;

  initial begin
    vecs[0]  = '{0, 32'h0000_00F0,  5'd4, 2'b00, 32'h0000_0F00};
    vecs[1]  = '{1, 32'h8000_0000, 5'd31, 2'b01, 32'hFFFF_FFFF};
    vecs[2]  = '{2, 32'h8000_0000, 5'd31, 2'b11, 32'h0000_0001};
    vecs[3]  = '{3, 32'h8000_0000,  5'd0, 2'b00, 32'h8000_0000};
    vecs[4]  = '{0, 32'h8000_0000,  5'd0, 2'b01, 32'h8000_0000};
    vecs[5]  = '{1, 32'h8000_0000,  5'd0, 2'b11, 32'h8000_0000};
    vecs[6]  = '{2, 32'h8000_0000,  5'd0, 2'b10, 32'h8000_0000};
    vecs[7]  = '{3, 32'hF000_0001,  5'd4, 2'b01, 32'hFF00_0000};
    vecs[8]  = '{0, 32'hF000_0001,  5'd4, 2'b11, 32'h0F00_0000};
    vecs[9]  = '{1, 32'hF000_0001,  5'd4, 2'b10, 32'h0000_0010};
    vecs[10] = '{2, 32'h1234_5679, 5'd31, 2'b00, 32'h8000_0000};
    vecs[11] = '{3, 32'h7FFF_FFFF,  5'd1, 2'b01, 32'h3FFF_FFFF};

    rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b0;
    req_data = '0; req_amt = '0; req_op = '0;
    next();
    next();
    #1;
    chk_reset_vals("por");
    req_valid = '0;
    rst_n = 1'b1;
    next();

    // Vector table, one requester at a time
    for (int i = 0; i < 12; i++) begin
      single(vecs[i].k, vecs[i].d, vecs[i].a, vecs[i].op, rd, rid, lat, ok);
      chk($sformatf("vec%0d_done", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_data", i), rd, vecs[i].exp);
      chk($sformatf("vec%0d_id", i), 32'(rid), 32'(vecs[i].k));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
    end

    // All requesters held valid: accept order and spacing
    quiesce();
    rst_pulse();
    for (int k = 0; k < NREQ; k++) set_req(k, 32'(k + 1), 5'd0, 2'b00);
    req_valid = '1; rsp_ready = 1'b1;
    #1;
    nacc = 0; cyc = 0;
    while (nacc < 5 && cyc < 40) begin
      if (req_ready != '0) begin
        chk("rr_onehot", 32'($onehot(req_ready)), 32'd1);
        order[nacc] = -1;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) order[nacc] = k;
        when[nacc] = cyc;
        nacc++;
      end
      next(); #1; cyc++;
    end
    chk("rr_count", 32'(nacc), 32'd5);
    for (int i = 0; i < nacc; i++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'd0);
`else
      chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % NREQ));
`endif
      if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(when[i] - when[i-1]), 32'd3);
    end

    // Response backpressure holds RESP stable
    quiesce();
    set_req(2, 32'h0000_00A5, 5'd3, 2'b00);
    req_valid = 4'b0100; rsp_ready = 1'b0;
    #1;
    n = 0;
    while (!req_ready[2] && n < 20) begin next(); #1; n++; end
    chk("bp_accept", 32'(req_ready), 32'h4);
    next();
    req_valid = '1;
    #1;
    n = 0;
    while (!rsp_valid && n < 10) begin next(); #1; n++; end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_data%0d", i), rsp_data, 32'h0000_0528);
      chk($sformatf("bp_id%0d", i), 32'(rsp_id), 32'd2);
      chk($sformatf("bp_ready%0d", i), 32'(req_ready), 32'd0);
      chk($sformatf("bp_busy%0d", i), 32'(busy), 32'd1);
      next(); #1;
    end
    rsp_ready = 1'b1;
    next(); #1;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    chk("bp_resume", 32'(req_ready), 32'h1);
`else
    chk("bp_resume", 32'(req_ready), 32'h8);
`endif

    // Reset during SHIFT discards the operation and restores the pointer
    quiesce();
    set_req(1, 32'hDEAD_BEEF, 5'd8, 2'b11);
    req_valid = 4'b0010;
    #1;
    n = 0;
    while (!req_ready[1] && n < 20) begin next(); #1; n++; end
    chk("mid_accept", 32'(req_ready), 32'h2);
    next();
    req_valid = '0;
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    next();
    next();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid || busy) flag = 1'b1;
      next(); #1;
    end
    chk("mid_no_rsp", 32'(flag), 32'd0);
    req_valid = 4'b1001;
    #1;
    chk("mid_ptr_reset", 32'(req_ready), 32'h1);
    quiesce();

    // Randomized traffic against the scoreboard
    rst_pulse();
    mptr = 0;
    v = '0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      if (c < 500) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!v[k]) begin
            if ($urandom_range(0, 2) == 0) begin
              v[k]    = 1'b1;
              rdat[k] = $urandom;
              ramt[k] = 5'($urandom_range(0, 31));
              rop[k]  = 2'($urandom_range(0, 3));
            end
          end else if ($urandom_range(0, 15) == 0) begin
            v[k] = 1'b0;
          end
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        rsp_ready = 1'b1;
      end
      for (int k = 0; k < NREQ; k++) set_req(k, rdat[k], ramt[k], rop[k]);
      req_valid = v;
      #1;
      if (req_ready != '0) begin
        w = model_pick(v, mptr);
        chk("rand_grant", 32'(req_ready), (w < 0) ? 32'd0 : 32'(1) << w);
        if (w >= 0) begin
          q.push_back({2'(w), model_shift(rdat[w], ramt[w], rop[w])});
          mptr = model_next_ptr(w);
          v[w] = 1'b0;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("rand_data", rsp_data, e[31:0]);
          chk("rand_id", 32'(rsp_id), 32'(e[33:32]));
        end
      end
      next();
    end
    chk("rand_all_accepted", 32'(v), 32'd0);
    chk("rand_queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/shift_arb.md
SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requester ports (2..8).
REQ-002 Parameter RR_INIT, default 0, requester index holding top priority after reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept strobe; at most one bit high per cycle.
REQ-007 req_data  input  NREQ*32  operand; requester i at bits [32i+31:32i].
REQ-008 req_amt  input  NREQ*5  shift amount; requester i at bits [5i+4:5i].
REQ-009 req_op  input  NREQ*2  per requester {a_or_h, l_or_r}: x0 left, 01 arithmetic right, 11 logical right.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_data  output  32  shifted result.
REQ-013 rsp_id  output  clog2(NREQ)  index of requester owning rsp_data.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 Block SHALL share one 32-bit combinational shifter among NREQ requesters via FSM IDLE -> SHIFT -> RESP -> IDLE.
REQ-016 IDLE: if any req_valid high, SHALL select winner, drive req_ready[winner]=1 that cycle, capture its data/amt/op/index, go SHIFT; else stay IDLE, req_ready all 0.
REQ-017 A transfer SHALL occur only when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-018 req_ready SHALL be 0 in SHIFT and RESP.
REQ-019 SHIFT: SHALL register shifter output into rsp_data and captured index into rsp_id, go RESP (one cycle).
REQ-020 RESP: rsp_valid=1, rsp_data/rsp_id stable until rsp_ready=1; on handshake SHALL go IDLE.
REQ-021 Latency: accept at cycle N -> rsp_valid high at N+2; peak throughput one operation per 3 cycles.
REQ-022 Round-robin: priority pointer starts at RR_INIT; winner = first valid requester at or after pointer, wrapping from NREQ-1 to 0; after accept pointer SHALL become (winner+1) mod NREQ.
REQ-023 Shift amount SHALL use only 5 bits; amount 0 SHALL return operand unchanged for every op.
REQ-024 Arithmetic right SHALL replicate bit 31 into vacated bits; left and logical right SHALL fill zeros.
REQ-025 Requester may drop req_valid before acceptance; winner SHALL be recomputed every IDLE cycle from current req_valid.
REQ-026 Requests arriving during SHIFT/RESP SHALL wait; none dropped while req_valid held.

Reset
REQ-027 While rst_n=0: state IDLE, pointer RR_INIT, req_ready 0, rsp_valid 0, rsp_data 0, rsp_id 0, busy 0.
REQ-028 Reset asserted mid-operation SHALL discard the in-flight operation with no response after release.

Configuration
REQ-029 With SHIFT_ARB_FIXED_PRIO_EN defined: fixed priority, lowest-index valid requester always wins, pointer logic removed, RR_INIT ignored.
REQ-030 Without SHIFT_ARB_FIXED_PRIO_EN: round-robin per REQ-022.

Structure
REQ-031 Package shift_arb_pkg SHALL hold FSM state encoding, op encodings (SHL, SAR, SHR), amount width 5, data width 32.
REQ-032 Winner selection SHALL be sub-module shift_arb_pick (req_valid, pointer -> one-hot grant, index); shifting uses one instance of the team's existing 32-bit shifter.

Verification
REQ-033 Single requester 0: data 0x0000_00F0, amt 4, op left -> rsp_data 0x0000_0F00, rsp_id 0, rsp_valid at accept+2.
REQ-034 data 0x8000_0000, amt 31, op 01 -> 0xFFFF_FFFF; same with op 11 -> 0x0000_0001; amt 0 any op -> 0x8000_0000.
REQ-035 All four req_valid held high, rsp_ready=1 -> accept order 0,1,2,3,0; with SHIFT_ARB_FIXED_PRIO_EN -> 0,0,0...
REQ-036 rsp_ready held 0 for 5 cycles in RESP -> rsp_data/rsp_id stable, req_ready all 0, busy 1; accept resumes only after rsp_ready.
REQ-037 rst_n pulsed low during SHIFT -> all outputs at reset values, no rsp_valid after release until a new request.
